// File: rtl/uart_rx_pkg.sv
// Shared types and timing helpers for the UART receiver.
package uart_rx_pkg;

   // Receiver FSM states.
   typedef enum logic [2:0] {
      Idle,
      Start,
      Data,
      Stop,
      Break
   } rx_state_e;

   // Clock cycles per bit, rounded to nearest.
   function automatic int unsigned calc_bit_cycles(input int unsigned clk_freq,
                                                   input int unsigned baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

   // Clock cycles per half bit.
   function automatic int unsigned calc_half_cycles(input int unsigned clk_freq,
                                                    input int unsigned baud);
      return calc_bit_cycles(clk_freq, baud) / 2;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 and flags the half and full points.
module uart_baud_counter #(
   parameter int unsigned BIT_CYCLES  = 434,
   parameter int unsigned HALF_CYCLES = 217
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic half_tick,
   output logic full_tick
);

   localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   logic [CW-1:0] count;

   assign half_tick = (count == CW'(HALF_CYCLES - 1));
   assign full_tick = (count == CW'(BIT_CYCLES - 1));

   // Free-running period counter, held at zero while restart is high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (restart || full_tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default: mid-bit sampling, valid strobe and framing-error strobe.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD      = 115200,
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 send,
   output logic                 fe
);

   localparam int unsigned BIT_CYCLES  = calc_bit_cycles(CLK_FREQ, BAUD);
   localparam int unsigned HALF_CYCLES = calc_half_cycles(CLK_FREQ, BAUD);
   localparam int unsigned IW          = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   rx_state_e            state_q;
   logic                 rx_meta;
   logic                 rx_s;
   logic [DATA_BITS-1:0] shreg;
   logic [IW-1:0]        bit_idx;
   logic                 restart;
   logic                 half_tick;
   logic                 full_tick;

   // Counter is parked at zero while waiting for a start edge or for a break to end,
   // and realigned once the start bit is validated so data samples land mid-bit.
   assign restart = (state_q == Idle) || (state_q == Break) ||
                    ((state_q == Start) && half_tick);

   uart_baud_counter #(
      .BIT_CYCLES  (BIT_CYCLES),
      .HALF_CYCLES (HALF_CYCLES)
   ) u_baud_counter (
      .clk       (clk),
      .reset_n   (reset_n),
      .restart   (restart),
      .half_tick (half_tick),
      .full_tick (full_tick)
   );

   // Two-flop synchroniser, reset to the idle (high) line level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Receive FSM with shift register and registered strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= Idle;
         data    <= '0;
         send    <= 1'b0;
         fe      <= 1'b0;
         shreg   <= '0;
         bit_idx <= '0;
      end else begin
         send <= 1'b0;
         fe   <= 1'b0;
         unique case (state_q)
            Idle: begin
               if (!rx_s) begin
                  state_q <= Start;
               end
            end
            Start: begin
               if (half_tick) begin
                  if (!rx_s) begin
                     state_q <= Data;
                     bit_idx <= '0;
                  end else begin
                     // Line went high again before mid start bit: glitch.
                     state_q <= Idle;
                  end
               end
            end
            Data: begin
               if (full_tick) begin
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_idx == IW'(DATA_BITS - 1)) begin
                     state_q <= Stop;
                  end else begin
                     bit_idx <= bit_idx + IW'(1);
                  end
               end
            end
            Stop: begin
               if (full_tick) begin
                  if (rx_s) begin
                     data    <= shreg;
                     send    <= 1'b1;
                     state_q <= Idle;
                  end else begin
                     fe      <= 1'b1;
                     state_q <= Break;
                  end
               end
            end
            Break: begin
               // A held-low line reports one framing error, then waits for idle.
               if (rx_s) begin
                  state_q <= Idle;
               end
            end
            default: state_q <= Idle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: table of frames plus hand-written corner cases.
module tb_uart_rx;
   import uart_rx_pkg::*;

   localparam int BIT = 434;

   logic       clk;
   logic       reset_n;
   logic       rx;
   logic [7:0] data;
   logic       send;
   logic       fe;

   int total = 0;
   int bad   = 0;

   int cyc           = 0;
   int send_cnt      = 0;
   int fe_cnt        = 0;
   int both_cnt      = 0;
   int last_send_cyc = 0;
   int start_cyc     = 0;
   logic [7:0] last_data = 8'h00;

   typedef struct {
      logic [7:0] val;
      int         per;
      int         exp_send;
      int         exp_fe;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[12];

   uart_rx dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rx      (rx),
      .data    (data),
      .send    (send),
      .fe      (fe)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (send) begin
         send_cnt      <= send_cnt + 1;
         last_data     <= data;
         last_send_cyc <= cyc;
      end
      if (fe) fe_cnt <= fe_cnt + 1;
      if (send && fe) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic send_frame(input logic [7:0] v, input int per, input logic stop);
      @(negedge clk);
      rx = 1'b0;
      start_cyc = cyc;
      repeat (per) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = v[i];
         repeat (per) @(negedge clk);
      end
      rx = stop;
      repeat (per) @(negedge clk);
      rx = 1'b1;
   endtask

   initial begin
      int s0;
      int f0;
      logic [7:0] d0;

      vecs[0]  = '{8'h40, BIT, 1, 0, 8'h40};
      vecs[1]  = '{8'h00, BIT, 1, 0, 8'h00};
      vecs[2]  = '{8'hFF, BIT, 1, 0, 8'hFF};
      vecs[3]  = '{8'h81, BIT, 1, 0, 8'h81};
      vecs[4]  = '{8'h00, 445, 1, 0, 8'h00};
      vecs[5]  = '{8'hFF, 445, 1, 0, 8'hFF};
      vecs[6]  = '{8'h81, 445, 1, 0, 8'h81};
      vecs[7]  = '{8'h00, 423, 1, 0, 8'h00};
      vecs[8]  = '{8'hFF, 423, 1, 0, 8'hFF};
      vecs[9]  = '{8'h81, 423, 1, 0, 8'h81};
      vecs[10] = '{8'hC6, BIT, 1, 0, 8'hC6};
      vecs[11] = '{8'h5A, 423, 1, 0, 8'h5A};

      rx      = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_data", 32'(data), 32'h0);
      check("reset_send", 32'(send), 32'h0);
      check("reset_fe", 32'(fe), 32'h0);
      reset_n = 1'b1;

      // Idle line for 10 bit times.
      repeat (10 * BIT) @(negedge clk);
      check("idle_send", 32'(send_cnt), 32'h0);
      check("idle_fe", 32'(fe_cnt), 32'h0);
      check("idle_data", 32'(data), 32'h0);

      // Table of frames, sent back to back.
      for (int i = 0; i < 12; i++) begin
         s0 = send_cnt;
         f0 = fe_cnt;
         send_frame(vecs[i].val, vecs[i].per, 1'b1);
         check($sformatf("vec%0d_send", i), 32'(send_cnt - s0), 32'(vecs[i].exp_send));
         check($sformatf("vec%0d_fe", i), 32'(fe_cnt - f0), 32'(vecs[i].exp_fe));
         check($sformatf("vec%0d_data", i), 32'(last_data), 32'(vecs[i].exp_data));
         if (vecs[i].per == BIT)
            check_range($sformatf("vec%0d_latency", i), last_send_cyc - start_cyc, 4124, 4126);
      end
      check("hold_data", 32'(data), 32'h5A);

      // Stop bit low, then line held low 20 bit times: exactly one fe.
      s0 = send_cnt;
      f0 = fe_cnt;
      d0 = data;
      send_frame(8'h55, BIT, 1'b0);
      rx = 1'b0;
      repeat (20 * BIT) @(negedge clk);
      check("brk_fe", 32'(fe_cnt - f0), 32'h1);
      check("brk_send", 32'(send_cnt - s0), 32'h0);
      check("brk_data", 32'(data), 32'(d0));
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      s0 = send_cnt;
      send_frame(8'hA3, BIT, 1'b1);
      check("after_brk_send", 32'(send_cnt - s0), 32'h1);
      check("after_brk_data", 32'(last_data), 32'hA3);

      // Short low glitch: rejected at mid start bit.
      s0 = send_cnt;
      f0 = fe_cnt;
      @(negedge clk);
      rx = 1'b0;
      repeat (100) @(negedge clk);
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
      check("glitch_send", 32'(send_cnt - s0), 32'h0);
      check("glitch_fe", 32'(fe_cnt - f0), 32'h0);
      check("glitch_state", 32'(dut.state_q), 32'(Idle));

      // Reset during bit 4 of a frame.
      s0 = send_cnt;
      @(negedge clk);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         repeat (BIT) @(negedge clk);
      end
      rx = 1'b0;
      repeat (BIT / 2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst_mid_data", 32'(data), 32'h0);
      check("rst_mid_send", 32'(send), 32'h0);
      check("rst_mid_fe", 32'(fe), 32'h0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (4 * BIT) @(negedge clk);
      check("rst_mid_nostrobe", 32'(send_cnt - s0), 32'h0);
      send_frame(8'h3C, BIT, 1'b1);
      check("after_rst_send", 32'(send_cnt - s0), 32'h1);
      check("after_rst_data", 32'(last_data), 32'h3C);
      check("after_rst_port", 32'(data), 32'h3C);

      check("send_fe_overlap", 32'(both_cnt), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
